pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00, PC value loaded on reset.
REQ-002 SHALL have parameter INSTR_W, default 32, instruction word width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port next_pc, input, 8, next address from the branch/PC+4 adder, computed from pc_out.
REQ-006 SHALL have port imem_req, output, 1, instruction memory read request.
REQ-007 SHALL have port imem_addr, output, 8, read address; equals current PC.
REQ-008 SHALL have port imem_ack, input, 1, memory read completion; imem_rdata valid in the same cycle.
REQ-009 SHALL have port imem_rdata, input, INSTR_W, fetched instruction word.
REQ-010 SHALL have port instr_valid, output, 1, instr/pc_out hold a fetched instruction.
REQ-011 SHALL have port instr_ready, input, 1, decode stage accepts the instruction.
REQ-012 SHALL have port instr, output, INSTR_W, registered fetched instruction.
REQ-013 SHALL have port pc_out, output, 8, address of instr; feeds the adder.
REQ-014 SHALL have port fault, output, 1, sticky misaligned-PC indication.
REQ-015 SHALL have port retired, output, 16, count of instructions accepted by decode.

Function
REQ-016 SHALL implement FSM states REQ, VALID, FAULT.
REQ-017 In REQ: imem_req=1, imem_addr=PC, instr_valid=0; on imem_ack, capture imem_rdata into instr and move to VALID.
REQ-018 imem_req SHALL stay high until imem_ack; a request is never withdrawn.
REQ-019 imem_ack SHALL be ignored in VALID and FAULT.
REQ-020 In VALID: imem_req=0, instr_valid=1; instr and pc_out stay stable until instr_ready=1.
REQ-021 On instr_valid && instr_ready: PC <= next_pc; retired increments by 1; if next_pc[1:0]==2'b00, go to REQ, otherwise go to FAULT.
REQ-022 Latency: ack in cycle N gives instr_valid=1 in cycle N+1; acceptance in cycle M gives imem_req=1 with the new address in cycle M+1.
REQ-023 Minimum throughput SHALL be one instruction per 2 cycles, with ack in the first REQ cycle and ready in the first VALID cycle.
REQ-024 PC SHALL wrap modulo 256: next_pc 8'h00 after PC 8'hFC is legal.
REQ-025 retired SHALL saturate at 16'hFFFF.
REQ-026 In FAULT: fault=1, imem_req=0, instr_valid=0; the block holds until reset.
REQ-027 The misaligned next_pc value SHALL be loaded into PC and shown on pc_out in FAULT.
REQ-028 pc_out SHALL equal PC in all states.

Reset
REQ-029 rst_n low SHALL immediately, without a clock edge, force: state=REQ, PC=RESET_PC, instr=0, retired=0, fault=0, instr_valid=0.
REQ-030 While rst_n is low, imem_req SHALL be 0.
REQ-031 The first cycle after rst_n deasserts SHALL have imem_req=1 and imem_addr=RESET_PC.
REQ-032 Reset asserted mid-fetch (REQ or VALID) SHALL discard the pending instruction; a late imem_ack during reset is ignored.

Verification
REQ-033 Reset then ack after 3 wait cycles with rdata 32'h00500093 -> imem_addr 8'h00; instr_valid rises the cycle after ack; instr=32'h00500093; pc_out=8'h00.
REQ-034 Back-to-back: ack and ready always high, next_pc=pc_out+4 -> instr_valid every other cycle; pc_out sequence 00,04,08,0C; retired=4 after 4 accepts.
REQ-035 Backpressure: instr_ready held low 5 cycles in VALID -> instr/pc_out stable, imem_req=0, retired unchanged; accept on cycle 6.
REQ-036 Branch: at pc_out=8'h10, next_pc=8'h08 on accept -> next request imem_addr=8'h08; pc_out=8'hFC with next_pc=8'h00 -> wrap accepted, no fault.
REQ-037 Misaligned: next_pc=8'h12 on accept -> fault=1 next cycle; pc_out=8'h12; imem_req stays 0 for 10+ cycles; rst_n low clears fault.
REQ-038 Async reset: rst_n pulled low between clock edges in VALID -> instr_valid=0 and pc_out=RESET_PC before the next edge.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Instruction fetch front end. Requests the word at the current PC from
//   instruction memory and holds it until the decode stage takes it. On
//   acceptance the PC is loaded from the external next_pc adder. A misaligned
//   next_pc parks the block in a sticky fault state until reset.
//
// Parameters
//   RESET_PC    PC value loaded on reset
//   INSTR_W     instruction word width
//
// Ports
//   clk          in   1        clock, rising edge
//   rst_n        in   1        asynchronous active-low reset
//   next_pc      in   8        next address from branch / PC+4 adder
//   imem_req     out  1        instruction memory read request
//   imem_addr    out  8        read address (current PC)
//   imem_ack     in   1        read completion, imem_rdata valid this cycle
//   imem_rdata   in   INSTR_W  fetched instruction word
//   instr_valid  out  1        instr / pc_out hold a fetched instruction
//   instr_ready  in   1        decode stage accepts the instruction
//   instr        out  INSTR_W  registered fetched instruction
//   pc_out       out  8        address of instr, feeds the adder
//   fault        out  1        sticky misaligned-PC indication
//   retired      out  16       saturating count of accepted instructions

module pc_fetch_unit #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter int         INSTR_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         next_pc,
  output logic               imem_req,
  output logic [7:0]         imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [7:0]         pc_out,
  output logic               fault,
  output logic [15:0]        retired
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_VALID = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [7:0] pc;
  logic       capture;
  logic       accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_REQ;
    end else begin
      state <= next_state;
    end
  end

  // imem_req is qualified with rst_n: the state register already sits in
  // S_REQ while reset is held, but no request may be issued until release.
  always_comb begin
    next_state  = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    fault       = 1'b0;
    capture     = 1'b0;
    accept      = 1'b0;
    case (state)
      S_REQ: begin
        imem_req = rst_n;
        if (imem_ack) begin
          capture    = 1'b1;
          next_state = S_VALID;
        end
      end
      S_VALID: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          accept     = 1'b1;
          next_state = (next_pc[1:0] == 2'b00) ? S_REQ : S_FAULT;
        end
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        next_state = S_REQ;
      end
    endcase
  end

  // The misaligned next_pc is still loaded on acceptance so pc_out shows the
  // offending address while in fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      instr   <= '0;
      retired <= '0;
    end else begin
      if (capture) begin
        instr <= imem_rdata;
      end
      if (accept) begin
        pc <= next_pc;
        if (retired != 16'hFFFF) begin
          retired <= retired + 16'd1;
        end
      end
    end
  end

  assign imem_addr = pc;
  assign pc_out    = pc;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit
//   Directed self-checking bench for pc_fetch_unit: reset values, wait-state
//   fetch, backpressure, back-to-back streaming, branch and wrap, async reset
//   in VALID, and misaligned-PC fault.

module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [7:0]  next_pc;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [7:0]  pc_out;
  logic        fault;
  logic [15:0] retired;

  int check_count = 0;
  int fail_count  = 0;

  logic [7:0]  exp_pc;
  logic [15:0] exp_retired;
  logic [31:0] exp_instr;

  pc_fetch_unit #(
    .RESET_PC (8'h00),
    .INSTR_W  (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .next_pc     (next_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .pc_out      (pc_out),
    .fault       (fault),
    .retired     (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance one clock edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ack, input logic [31:0] rdata,
                               input logic ready, input logic [7:0] npc);
    imem_ack    = ack;
    imem_rdata  = rdata;
    instr_ready = ready;
    next_pc     = npc;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 32'h0, 1'b0, 8'h00);
    rst_n = 1'b0;
    #3;
    checkOutput("rst_req", {31'b0, imem_req}, 32'd0);
    checkOutput("rst_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("rst_fault", {31'b0, fault}, 32'd0);
    checkOutput("rst_pc", {24'b0, pc_out}, 32'h00);
    checkOutput("rst_instr", instr, 32'h0);
    checkOutput("rst_retired", {16'b0, retired}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_req", {31'b0, imem_req}, 32'd1);
    checkOutput("post_rst_addr", {24'b0, imem_addr}, 32'h00);
    exp_pc      = 8'h00;
    exp_retired = 16'd0;
  endtask

  // One fetch with ack in the first REQ cycle and ready in the first VALID
  // cycle, then acceptance with the given next_pc.
  task automatic fetchAccept(input logic [7:0] npc);
    exp_instr = 32'hA5000000 | {24'b0, exp_pc};
    checkOutput("ff_req", {31'b0, imem_req}, 32'd1);
    checkOutput("ff_addr", {24'b0, imem_addr}, {24'b0, exp_pc});
    applyStimulus(1'b1, exp_instr, 1'b1, npc);
    step();
    checkOutput("ff_valid", {31'b0, instr_valid}, 32'd1);
    checkOutput("ff_pc", {24'b0, pc_out}, {24'b0, exp_pc});
    checkOutput("ff_instr", instr, exp_instr);
    checkOutput("ff_req_low", {31'b0, imem_req}, 32'd0);
    step();
    exp_pc      = npc;
    exp_retired = exp_retired + 16'd1;
    checkOutput("ff_retired", {16'b0, retired}, {16'b0, exp_retired});
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 8'h00);

    // Fetch with three wait cycles, then backpressure.
    doReset();
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("wait_req", {31'b0, imem_req}, 32'd1);
      checkOutput("wait_valid", {31'b0, instr_valid}, 32'd0);
    end
    applyStimulus(1'b1, 32'h00500093, 1'b0, 8'h04);
    step();
    applyStimulus(1'b0, 32'hDEADBEEF, 1'b0, 8'h04);
    checkOutput("f1_valid", {31'b0, instr_valid}, 32'd1);
    checkOutput("f1_instr", instr, 32'h00500093);
    checkOutput("f1_pc", {24'b0, pc_out}, 32'h00);
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("bp_valid", {31'b0, instr_valid}, 32'd1);
      checkOutput("bp_instr", instr, 32'h00500093);
      checkOutput("bp_pc", {24'b0, pc_out}, 32'h00);
      checkOutput("bp_req", {31'b0, imem_req}, 32'd0);
      checkOutput("bp_retired", {16'b0, retired}, 32'd0);
    end
    instr_ready = 1'b1;
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 8'h00);
    checkOutput("bp_acc_retired", {16'b0, retired}, 32'd1);
    checkOutput("bp_acc_req", {31'b0, imem_req}, 32'd1);
    checkOutput("bp_acc_addr", {24'b0, imem_addr}, 32'h04);
    checkOutput("bp_acc_valid", {31'b0, instr_valid}, 32'd0);

    // Back-to-back streaming, then branch and wrap.
    doReset();
    for (int i = 0; i < 4; i++) begin
      fetchAccept(exp_pc + 8'd4);
    end
    checkOutput("b2b_retired", {16'b0, retired}, 32'd4);
    checkOutput("b2b_addr", {24'b0, imem_addr}, 32'h10);
    fetchAccept(8'h08);
    checkOutput("branch_addr", {24'b0, imem_addr}, 32'h08);
    fetchAccept(8'hFC);
    fetchAccept(8'h00);
    checkOutput("wrap_fault", {31'b0, fault}, 32'd0);
    checkOutput("wrap_req", {31'b0, imem_req}, 32'd1);
    checkOutput("wrap_addr", {24'b0, imem_addr}, 32'h00);
    checkOutput("wrap_retired", {16'b0, retired}, 32'd7);

    // Async reset between edges while in VALID, with a late ack held high.
    applyStimulus(1'b1, 32'h11111111, 1'b0, 8'h04);
    fetchAccept(8'h04);
    applyStimulus(1'b1, 32'h22222222, 1'b0, 8'h08);
    step();
    checkOutput("ar_pre_valid", {31'b0, instr_valid}, 32'd1);
    checkOutput("ar_pre_pc", {24'b0, pc_out}, 32'h04);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("ar_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("ar_pc", {24'b0, pc_out}, 32'h00);
    checkOutput("ar_req", {31'b0, imem_req}, 32'd0);
    checkOutput("ar_instr", instr, 32'h0);
    step();
    checkOutput("ar_hold_req", {31'b0, imem_req}, 32'd0);
    checkOutput("ar_hold_instr", instr, 32'h0);

    // Misaligned next_pc leads to sticky fault.
    doReset();
    fetchAccept(8'h12);
    checkOutput("mis_fault", {31'b0, fault}, 32'd1);
    checkOutput("mis_pc", {24'b0, pc_out}, 32'h12);
    checkOutput("mis_valid", {31'b0, instr_valid}, 32'd0);
    applyStimulus(1'b1, 32'h33333333, 1'b1, 8'h20);
    for (int i = 0; i < 10; i++) begin
      step();
      checkOutput("mis_hold_req", {31'b0, imem_req}, 32'd0);
      checkOutput("mis_hold_fault", {31'b0, fault}, 32'd1);
      checkOutput("mis_hold_pc", {24'b0, pc_out}, 32'h12);
    end
    checkOutput("mis_retired", {16'b0, retired}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mis_clr_fault", {31'b0, fault}, 32'd0);
    checkOutput("mis_clr_pc", {24'b0, pc_out}, 32'h00);
    doReset();

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
